// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
// pipeline_stall_ctrl : hold/flush control for the five-stage pipeline
// (load-use, multi-cycle divide, data-memory wait) with a stall-cycle counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_1_ID,
    input  logic [ADDR_W-1:0] raddr_2_ID,
    input  logic              use_rs_ID,
    input  logic              use_rt_ID,
    input  logic              ReadMem_EX,
    input  logic [ADDR_W-1:0] dest_EX,
    input  logic              div_start_EX,
    input  logic              mem_req_MEM,
    input  logic              mem_ack,
    output logic              hold_PC,
    output logic              hold_IF_ID,
    output logic              hold_ID_EX,
    output logic              hold_EX_MEM,
    output logic              hold_MEM_WB,
    output logic              flush_ID_EX,
    output logic              flush_EX_MEM,
    output logic              flush_MEM_WB,
    output logic              div_busy,
    output logic              div_done,
    output logic [PERF_W-1:0] stall_count
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_blk_q, div_blk_d;
    logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic w_mem_stall;
    logic w_lu;
    logic w_div_go;
    logic w_div_stall;
    logic w_div_done;
    logic w_hold_pc;
    logic w_hold_id_ex;

    assign w_mem_stall = mem_req_MEM & ~mem_ack;
    assign w_lu        = ReadMem_EX & (dest_EX != '0) &
                         ((use_rs_ID & (raddr_1_ID == dest_EX)) |
                          (use_rt_ID & (raddr_2_ID == dest_EX)));
    assign w_div_go    = (state_q == RUN) & div_start_EX & ~div_blk_q;
    assign w_div_stall = w_div_go | (state_q == DIV_WAIT);
    assign w_div_done  = (state_q == DIV_WAIT) & (cnt_q == '0);

    assign w_hold_pc    = w_mem_stall | w_div_stall | w_lu;
    assign w_hold_id_ex = w_mem_stall | w_div_stall;

    // Every output is forced low while reset is asserted, independent of inputs.
    assign hold_PC      = rst & w_hold_pc;
    assign hold_IF_ID   = rst & w_hold_pc;
    assign hold_ID_EX   = rst & w_hold_id_ex;
    assign hold_EX_MEM  = rst & w_mem_stall;
    assign hold_MEM_WB  = rst & w_mem_stall;
    // A stage held by a downstream stall must not also be bubbled; MEM_WB's
    // bubble comes from the memory stall itself and is therefore kept.
    assign flush_ID_EX  = rst & w_lu & ~w_hold_id_ex;
    assign flush_EX_MEM = rst & w_div_stall & ~w_mem_stall;
    assign flush_MEM_WB = rst & w_mem_stall;
    assign div_busy     = rst & (state_q == DIV_WAIT);
    assign div_done     = rst & w_div_done;
    assign stall_count  = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_blk_d   = div_blk_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            RUN: begin
                if (w_div_go) begin
                    state_d = DIV_WAIT;
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            DIV_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        // The finished divide stays latched in ID_EX until it is allowed to advance.
        if (w_div_done) begin
            div_blk_d = 1'b1;
        end else if (!w_hold_id_ex) begin
            div_blk_d = 1'b0;
        end

        if (w_hold_pc && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            div_blk_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_blk_q   <= div_blk_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
// ============================================================================
// tb_pipeline_stall_ctrl : scoreboard bench with a cycle-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_stall_ctrl;

    localparam int ADDR_W     = 5;
    localparam int DIV_CYCLES = 4;
    localparam int CNT_W      = 3;
    localparam int PERF_W     = 4;
    localparam int SAT        = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] raddr_1_ID = '0, raddr_2_ID = '0, dest_EX = '0;
    logic              use_rs_ID = 0, use_rt_ID = 0, ReadMem_EX = 0;
    logic              div_start_EX = 0, mem_req_MEM = 0, mem_ack = 0;
    logic              hold_PC, hold_IF_ID, hold_ID_EX, hold_EX_MEM, hold_MEM_WB;
    logic              flush_ID_EX, flush_EX_MEM, flush_MEM_WB, div_busy, div_done;
    logic [PERF_W-1:0] stall_count;

    pipeline_stall_ctrl #(
        .ADDR_W(ADDR_W), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W), .PERF_W(PERF_W)
    ) dut (
        .clk(clk), .rst(rst),
        .raddr_1_ID(raddr_1_ID), .raddr_2_ID(raddr_2_ID),
        .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
        .ReadMem_EX(ReadMem_EX), .dest_EX(dest_EX),
        .div_start_EX(div_start_EX), .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
        .hold_PC(hold_PC), .hold_IF_ID(hold_IF_ID), .hold_ID_EX(hold_ID_EX),
        .hold_EX_MEM(hold_EX_MEM), .hold_MEM_WB(hold_MEM_WB),
        .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
        .div_busy(div_busy), .div_done(div_done), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // {holds[4:0], flushes[2:0], div_busy, div_done, stall_count}
    logic [10+PERF_W-1:0] exp_q[$];
    int vectors    = 0;
    int miscompares = 0;
    int cycle_no   = 0;

    // Reference model: divide tracked as "stall cycles still owed", counter as an int.
    int div_left = 0;
    bit div_blk  = 0;
    int perf     = 0;

    always @(negedge clk) begin
        logic [10+PERF_W-1:0] act, exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {hold_PC, hold_IF_ID, hold_ID_EX, hold_EX_MEM, hold_MEM_WB,
                   flush_ID_EX, flush_EX_MEM, flush_MEM_WB, div_busy, div_done, stall_count};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL cycle %0d: outputs actual=%b required=%b", cycle_no, act, exp);
            end
        end
    end

    task automatic step(input bit r, input int a1, input int a2, input bit urs, input bit urt,
                        input bit ld, input int dst, input bit dv, input bit req, input bit ack);
        bit mem, lu, busy, go, dstall, done, hpc, hidex;
        @(posedge clk);
        #1;
        cycle_no++;
        rst = r; raddr_1_ID = ADDR_W'(a1); raddr_2_ID = ADDR_W'(a2); dest_EX = ADDR_W'(dst);
        use_rs_ID = urs; use_rt_ID = urt; ReadMem_EX = ld;
        div_start_EX = dv; mem_req_MEM = req; mem_ack = ack;
        if (!r) begin
            div_left = 0; div_blk = 0; perf = 0;
            exp_q.push_back('0);
            return;
        end
        mem    = req && !ack;
        lu     = ld && (dst != 0) && ((urs && a1 == dst) || (urt && a2 == dst));
        busy   = (div_left > 0);
        go     = !busy && dv && !div_blk;
        dstall = go || busy;
        done   = (div_left == 1);
        hpc    = mem || dstall || lu;
        hidex  = mem || dstall;
        exp_q.push_back({hpc, hpc, hidex, mem, mem,
                         lu && !hidex, dstall && !mem, mem, busy, done, PERF_W'(perf)});
        if (go) div_left = DIV_CYCLES;
        else if (busy) div_left--;
        if (done) div_blk = 1;
        else if (!hidex) div_blk = 0;
        if (hpc && perf < SAT) perf++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Load-use on rs, then the same with dest 0
        step(1, 5, 0, 1, 0, 1, 5, 0, 0, 0);
        idle(1);
        step(1, 5, 0, 1, 0, 1, 0, 0, 0, 0);
        step(1, 3, 7, 0, 1, 1, 7, 0, 0, 0);
        idle(1);
        // Divide with start held one cycle past completion
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // Memory wait of three cycles
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        // Memory stall raised mid divide
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // Reset dropped with two wait cycles remaining
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);
        // Twenty consecutive stall cycles saturate the counter
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 9) < 3), $urandom_range(0, 3),
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 3),
                 $urandom_range(0, 1));
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
